// File: rtl/branch_control.sv
// -----------------------------------------------------------------------------
// branch_control
//
// Control-transfer decoder that sits behind the program counter's jump/branch
// interface. Every 5-cycle instruction slot (PC slot state 0..4) it captures
// the instruction at pc, reads two operands from the register file, resolves
// equality and presents address/jump/beq/bne/compare so the program counter
// can sample them on the state-4 clock edge. It also keeps a saturating count
// of taken transfers and a sticky flag for illegal slot states (5..7).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   pc           in   current program counter
//   state        in   program counter slot state, 0..4
//   instr        in   instruction memory data at pc
//   reg_a        in   register file data for rs_addr
//   reg_b        in   register file data for rt_addr
//   rs_addr      out  register read address, ir[11:8]
//   rt_addr      out  register read address, ir[7:4]
//   address      out  transfer target
//   jump         out  unconditional transfer (JMP or JR)
//   beq          out  conditional branch on equal
//   bne          out  conditional branch on not-equal
//   compare      out  registered reg_a == reg_b
//   taken_count  out  saturating count of taken transfers
//   state_err    out  sticky: state was seen at 5..7
//
// Build option:
//   BRANCH_RELATIVE_EN  defined   -> BEQ/BNE target = pc + 1 + sext(ir[3:0])
//                       undefined -> BEQ/BNE target = {pc[15:4], ir[3:0]}
// -----------------------------------------------------------------------------
module branch_control #(
    parameter int unsigned DATA_W  = 16,
    parameter logic [3:0]  OPC_JMP = 4'hC,
    parameter logic [3:0]  OPC_BEQ = 4'hD,
    parameter logic [3:0]  OPC_BNE = 4'hE,
    parameter logic [3:0]  OPC_JR  = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc,
    input  logic [2:0]        state,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    output logic [3:0]        rs_addr,
    output logic [3:0]        rt_addr,
    output logic [DATA_W-1:0] address,
    output logic              jump,
    output logic              beq,
    output logic              bne,
    output logic              compare,
    output logic [15:0]       taken_count,
    output logic              state_err
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [15:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] address_q, address_d;
    logic              jump_q, jump_d;
    logic              beq_q, beq_d;
    logic              bne_q, bne_d;
    logic              compare_q, compare_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [3:0]        opc;
    logic              is_jmp, is_beq, is_bne, is_jr, is_ctrl;
    logic              taken;
    logic [DATA_W-1:0] jmp_tgt;
    logic [DATA_W-1:0] br_tgt;

    assign opc     = ir_q[15:12];
    assign is_jmp  = (opc == OPC_JMP);
    assign is_beq  = (opc == OPC_BEQ);
    assign is_bne  = (opc == OPC_BNE);
    assign is_jr   = (opc == OPC_JR);
    assign is_ctrl = is_jmp | is_beq | is_bne | is_jr;

    assign jmp_tgt = {pc[DATA_W-1:12], ir_q[11:0]};

`ifdef BRANCH_RELATIVE_EN
    // Offset is a signed nibble relative to the following instruction.
    assign br_tgt = pc + DATA_W'(1) + {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
`else
    // Page-absolute: low pc bits are replaced, so they play no part here.
    logic unused_pc_low;
    assign unused_pc_low = ^pc[3:0];
    assign br_tgt        = {pc[DATA_W-1:4], ir_q[3:0]};
`endif

    assign taken = jump_q | (beq_q & compare_q) | (bne_q & ~compare_q);

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        address_d  = address_q;
        jump_d     = jump_q;
        beq_d      = beq_q;
        bne_d      = bne_q;
        compare_d  = compare_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        case (state)
            3'd0: begin
                ir_d       = instr;
                ir_valid_d = 1'b1;
            end
            3'd1: begin
                opa_d = reg_a;
                opb_d = reg_b;
            end
            3'd2: begin
                // ir_valid is low for a slot interrupted by reset, so a
                // partially sequenced slot never asserts a control output.
                if (ir_valid_q && is_ctrl) begin
                    compare_d = (opa_q == opb_q);
                    jump_d    = is_jmp | is_jr;
                    beq_d     = is_beq;
                    bne_d     = is_bne;
                    if (is_jmp) begin
                        address_d = jmp_tgt;
                    end else if (is_jr) begin
                        address_d = opa_q;
                    end else begin
                        address_d = br_tgt;
                    end
                end
            end
            3'd3: begin
            end
            3'd4: begin
                if (taken && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 16'd1;
                end
                jump_d     = 1'b0;
                beq_d      = 1'b0;
                bne_d      = 1'b0;
                compare_d  = 1'b0;
                ir_valid_d = 1'b0;
            end
            default: begin
                err_d      = 1'b1;
                jump_d     = 1'b0;
                beq_d      = 1'b0;
                bne_d      = 1'b0;
                compare_d  = 1'b0;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            address_q  <= '0;
            jump_q     <= 1'b0;
            beq_q      <= 1'b0;
            bne_q      <= 1'b0;
            compare_q  <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            address_q  <= address_d;
            jump_q     <= jump_d;
            beq_q      <= beq_d;
            bne_q      <= bne_d;
            compare_q  <= compare_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign rs_addr     = ir_q[11:8];
    assign rt_addr     = ir_q[7:4];
    assign address     = address_q;
    assign jump        = jump_q;
    assign beq         = beq_q;
    assign bne         = bne_q;
    assign compare     = compare_q;
    assign taken_count = cnt_q;
    assign state_err   = err_q;

endmodule

// File: tb/tb_branch_control.sv
// -----------------------------------------------------------------------------
// tb_branch_control
//
// Directed bench for branch_control. Each slot drives states 0..4 on the
// falling edge and snapshots the outputs 1 ns after every rising edge, so
// snap_*[s] is what the design shows after the edge taken in state s.
// -----------------------------------------------------------------------------
module tb_branch_control;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic [2:0]  state;
    logic [15:0] instr;
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] address;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        compare;
    logic [15:0] taken_count;
    logic        state_err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BRANCH_RELATIVE_EN
    localparam logic [15:0] BEQ_T  = 16'h0010;
    localparam logic [15:0] BNE2_T = 16'h010D;
    localparam logic [15:0] BEQ2_T = 16'h001B;
    localparam logic [15:0] WRAP_T = 16'h0007;
`else
    localparam logic [15:0] BEQ_T  = 16'h001F;
    localparam logic [15:0] BNE2_T = 16'h0105;
    localparam logic [15:0] BEQ2_T = 16'h002A;
    localparam logic [15:0] WRAP_T = 16'hFFF7;
`endif

    logic        snap_jump [5];
    logic        snap_beq  [5];
    logic        snap_bne  [5];
    logic        snap_cmp  [5];
    logic        snap_err  [5];
    logic [15:0] snap_addr [5];
    logic [15:0] snap_cnt  [5];
    logic [3:0]  snap_rs;
    logic [3:0]  snap_rt;

    branch_control dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .state       (state),
        .instr       (instr),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .address     (address),
        .jump        (jump),
        .beq         (beq),
        .bne         (bne),
        .compare     (compare),
        .taken_count (taken_count),
        .state_err   (state_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // rst_s: slot position at which reset is held for one cycle (-1 = none).
    // s3: state value driven in place of 3 (use 6 to inject an illegal state).
    task automatic run_slot(input logic [15:0] p, input logic [15:0] ins,
                            input logic [15:0] a, input logic [15:0] b,
                            input int rst_s, input logic [2:0] s3);
        pc    = p;
        instr = ins;
        reg_a = a;
        reg_b = b;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            state = (s == 3) ? s3 : 3'(s);
            reset = (s == rst_s);
            @(posedge clk);
            #1;
            snap_jump[s] = jump;
            snap_beq[s]  = beq;
            snap_bne[s]  = bne;
            snap_cmp[s]  = compare;
            snap_err[s]  = state_err;
            snap_addr[s] = address;
            snap_cnt[s]  = taken_count;
            if (s == 0) begin
                snap_rs = rs_addr;
                snap_rt = rt_addr;
            end
        end
        reset = 1'b0;
    endtask

    task automatic expect_slot(input string t, input logic ej, input logic eb,
                               input logic en, input logic ec,
                               input logic [15:0] ea, input logic [15:0] ecnt);
        check({t, "_jump_s1"}, 32'(snap_jump[1]), 32'(1'b0));
        check({t, "_jump"},    32'(snap_jump[2]), 32'(ej));
        check({t, "_beq"},     32'(snap_beq[2]),  32'(eb));
        check({t, "_bne"},     32'(snap_bne[2]),  32'(en));
        check({t, "_cmp"},     32'(snap_cmp[2]),  32'(ec));
        check({t, "_addr"},    32'(snap_addr[2]), 32'(ea));
        check({t, "_jump_s3"}, 32'(snap_jump[3]), 32'(ej));
        check({t, "_clr_s4"},  32'({snap_jump[4], snap_beq[4], snap_bne[4], snap_cmp[4]}), 32'(0));
        check({t, "_addr_s4"}, 32'(snap_addr[4]), 32'(ea));
        check({t, "_cnt"},     32'(snap_cnt[4]),  32'(ecnt));
    endtask

    initial begin
        reset = 1'b1;
        state = 3'd0;
        pc    = 16'h0;
        instr = 16'h0;
        reg_a = 16'h0;
        reg_b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({jump, beq, bne, compare}), 32'(0));
        check("rst_addr", 32'(address), 32'(0));
        check("rst_cnt",  32'(taken_count), 32'(0));
        check("rst_err",  32'(state_err), 32'(0));
        check("rst_rs",   32'(rs_addr), 32'(0));
        check("rst_rt",   32'(rt_addr), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Non-control opcode: nothing asserts, nothing counts.
        for (int k = 0; k < 5; k++) begin
            run_slot(16'h0100, 16'h1234, 16'h0007, 16'h0007, -1, 3'd3);
            check("nc_ctrl_s2", 32'({snap_jump[2], snap_beq[2], snap_bne[2]}), 32'(0));
            check("nc_ctrl_s3", 32'({snap_jump[3], snap_beq[3], snap_bne[3]}), 32'(0));
            check("nc_cnt",     32'(snap_cnt[4]), 32'(0));
        end
        check("nc_rs", 32'(snap_rs), 32'(4'h2));

        run_slot(16'h5003, 16'hCABC, 16'h0000, 16'h0000, -1, 3'd3);
        check("jmp_rs", 32'(snap_rs), 32'(4'hA));
        check("jmp_rt", 32'(snap_rt), 32'(4'hB));
        expect_slot("jmp", 1'b1, 1'b0, 1'b0, 1'b1, 16'h5ABC, 16'd1);
        check("jmp_cnt_s3", 32'(snap_cnt[3]), 32'(0));

        run_slot(16'h0010, 16'hD12F, 16'h0042, 16'h0042, -1, 3'd3);
        check("beq_rs", 32'(snap_rs), 32'(4'h1));
        check("beq_rt", 32'(snap_rt), 32'(4'h2));
        expect_slot("beq", 1'b0, 1'b1, 1'b0, 1'b1, BEQ_T, 16'd2);

        run_slot(16'h0010, 16'hE12F, 16'h0042, 16'h0042, -1, 3'd3);
        expect_slot("bne_eq", 1'b0, 1'b0, 1'b1, 1'b1, BEQ_T, 16'd2);

        run_slot(16'h1234, 16'hF300, 16'hFFFF, 16'h0000, -1, 3'd3);
        expect_slot("jr", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'd3);

        run_slot(16'h0107, 16'hE345, 16'h0001, 16'h0002, -1, 3'd3);
        expect_slot("bne_ne", 1'b0, 1'b0, 1'b1, 1'b0, BNE2_T, 16'd4);

        run_slot(16'h0020, 16'hD12A, 16'h0003, 16'h0004, -1, 3'd3);
        expect_slot("beq_ne", 1'b0, 1'b1, 1'b0, 1'b0, BEQ2_T, 16'd4);

        run_slot(16'hFFFF, 16'hD007, 16'h0005, 16'h0005, -1, 3'd3);
        expect_slot("beq_wrap", 1'b0, 1'b1, 1'b0, 1'b1, WRAP_T, 16'd5);

        // Illegal state in the hold position of a JMP slot.
        run_slot(16'h5003, 16'hCABC, 16'h0000, 16'h0000, -1, 3'd6);
        check("err_pre",   32'(snap_err[2]), 32'(0));
        check("err_set",   32'(snap_err[3]), 32'(1));
        check("err_clr",   32'({snap_jump[3], snap_beq[3], snap_bne[3], snap_cmp[3]}), 32'(0));
        check("err_nocnt", 32'(snap_cnt[4]), 32'(5));

        run_slot(16'h5003, 16'hCABC, 16'h0000, 16'h0000, -1, 3'd3);
        check("err_sticky", 32'(snap_err[4]), 32'(1));
        check("err_cnt",    32'(snap_cnt[4]), 32'(6));

        @(negedge clk);
        reset = 1'b1;
        state = 3'd0;
        @(posedge clk);
        #1;
        check("rst2_err", 32'(state_err), 32'(0));
        check("rst2_cnt", 32'(taken_count), 32'(0));
        reset = 1'b0;

        // Reset during state 2 of a JMP slot, then a clean JMP slot.
        run_slot(16'h5003, 16'hCABC, 16'h0000, 16'h0000, 2, 3'd3);
        check("rmid_jump_s3", 32'(snap_jump[3]), 32'(0));
        check("rmid_cnt",     32'(snap_cnt[4]), 32'(0));
        run_slot(16'h7001, 16'hC123, 16'h0000, 16'h0000, -1, 3'd3);
        expect_slot("rmid_next", 1'b1, 1'b0, 1'b0, 1'b1, 16'h7123, 16'd1);

        // Saturation: preload 0xFFFE, then three taken JMPs.
        @(negedge clk);
        state = 3'd0;
        force dut.cnt_q = 16'hFFFE;
        @(posedge clk);
        @(posedge clk);
        #1;
        release dut.cnt_q;
        check("sat_pre", 32'(taken_count), 32'(16'hFFFE));
        run_slot(16'h7001, 16'hC123, 16'h0000, 16'h0000, -1, 3'd3);
        check("sat_1", 32'(snap_cnt[4]), 32'(16'hFFFF));
        run_slot(16'h7001, 16'hC123, 16'h0000, 16'h0000, -1, 3'd3);
        check("sat_2", 32'(snap_cnt[4]), 32'(16'hFFFF));
        run_slot(16'h7001, 16'hC123, 16'h0000, 16'h0000, -1, 3'd3);
        check("sat_3", 32'(snap_cnt[4]), 32'(16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
